// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: skid stage state encoding and default datapath width.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int DATA_MSB = 31;

  function automatic logic [1:0] occ_of(input skid_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      BUSY:    n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage with a two-entry skid buffer; in_ready is decoded
// from registered state only, so it never depends on out_ready combinationally.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int EM = DATA_MSB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EM:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EM:0]   out_data,
  input  logic          flush,
  output logic [1:0]    occ
);

  skid_state_e state_q, state_d;
  logic [EM:0] main_q, skid_q;
  logic        load_main_in, load_main_skid, load_skid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Flush wins over every handshake and suppresses all data loads.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            load_main_in = 1'b1;
            state_d      = BUSY;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            load_main_in = 1'b1;
          end else if (in_valid) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            load_main_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              main_q <= '0;
    else if (load_main_in)   main_q <= in_data;
    else if (load_main_skid) main_q <= skid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         skid_q <= '0;
    else if (load_skid) skid_q <= in_data;
  end

  assign out_data  = main_q;
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign occ       = occ_of(state_q);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg: streaming, backpressure,
// flush and asynchronous reset.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [1:0]  occ;

  int checks = 0;
  int fails  = 0;

  pipe_skid_reg #(.EM(31)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .occ      (occ)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic v, input logic [31:0] d,
                          input logic r, input logic [1:0] o);
    checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    checkOutput({tag, ".out_data"},  out_data, d);
    checkOutput({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, r});
    checkOutput({tag, ".occ"},       {30'd0, occ}, {30'd0, o});
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #12;
    checkAll("reset", 1'b0, 32'h0, 1'b1, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      checkAll("idle", 1'b0, 32'h0, 1'b1, 2'd0);
    end

    // Full-throughput streaming
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0); step();
    checkAll("stream0", 1'b1, 32'h11, 1'b1, 2'd1);
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0); step();
    checkAll("stream1", 1'b1, 32'h22, 1'b1, 2'd1);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0); step();
    checkAll("stream2", 1'b1, 32'h33, 1'b1, 2'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); step();
    checkAll("drain", 1'b0, 32'h33, 1'b1, 2'd0);

    // Backpressure fills the skid entry
    applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0); step();
    checkAll("bp0", 1'b1, 32'hA0, 1'b1, 2'd1);
    applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0); step();
    checkAll("bp1", 1'b1, 32'hA0, 1'b0, 2'd2);
    applyStimulus(1'b1, 32'hFF, 1'b0, 1'b0); step();
    checkAll("fullhold0", 1'b1, 32'hA0, 1'b0, 2'd2);
    step();
    checkAll("fullhold1", 1'b1, 32'hA0, 1'b0, 2'd2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); step();
    checkAll("unskid", 1'b1, 32'hA1, 1'b1, 2'd1);
    step();
    checkAll("empty", 1'b0, 32'hA1, 1'b1, 2'd0);

    // Flush from FULL with out_ready high
    applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0); step();
    checkAll("refill", 1'b1, 32'hA0, 1'b0, 2'd2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); step();
    checkAll("flush", 1'b0, 32'hA0, 1'b1, 2'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); step();
    checkAll("postflush", 1'b0, 32'hA0, 1'b1, 2'd0);

    // Flush discards a same-cycle input transfer
    applyStimulus(1'b1, 32'hC0, 1'b0, 1'b0); step();
    checkAll("busyc0", 1'b1, 32'hC0, 1'b1, 2'd1);
    applyStimulus(1'b1, 32'hC1, 1'b1, 1'b1); step();
    checkAll("flushin", 1'b0, 32'hC0, 1'b1, 2'd0);

    // Asynchronous reset while FULL
    applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0); step();
    checkAll("prereset", 1'b1, 32'hB0, 1'b0, 2'd2);
    #2;
    reset = 1'b0;
    #1;
    checkAll("asyncreset", 1'b0, 32'h0, 1'b1, 2'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step();
    checkAll("afterreset", 1'b0, 32'h0, 1'b1, 2'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
